// File: rtl/fetch_ctl_pkg.sv
// Shared types and constants for the fetch/decode controller.
package fetch_ctl_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXEC    = 2'b01,
    OPERAND = 2'b10,
    HALT    = 2'b11
  } state_t;

  // Opcode class lives in ir[7:6]
  localparam logic [1:0] OPC_ALU  = 2'b00;
  localparam logic [1:0] OPC_LDI  = 2'b01;
  localparam logic [1:0] OPC_JMP  = 2'b10;
  localparam logic [1:0] OPC_MISC = 2'b11;

  localparam logic [7:0] OP_HALT = 8'hFF;

  // Jump condition codes in ir[1:0]
  localparam logic [1:0] COND_ALW = 2'b00;
  localparam logic [1:0] COND_Z   = 2'b01;
  localparam logic [1:0] COND_C   = 2'b10;
  localparam logic [1:0] COND_NZ  = 2'b11;

  function automatic logic [1:0] op_class(input logic [7:0] op);
    return op[7:6];
  endfunction

endpackage

// File: rtl/fetch_cond.sv
// Jump condition evaluation against the latched ALU flags.
module fetch_cond
  import fetch_ctl_pkg::*;
(
  input  logic [1:0] cond,
  input  logic       z,
  input  logic       c,
  output logic       taken
);

  // Select the flag test named by the condition code
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ALW: taken = 1'b1;
      COND_Z:   taken = z;
      COND_C:   taken = c;
      COND_NZ:  taken = ~z;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_ctl.sv
// Fetch/decode controller: FETCH / EXEC / OPERAND / HALT sequencer
// driving the PC, the instruction register, the immediate register and
// the ALU flags. Optional single-step gating via FETCH_CTL_SINGLE_STEP_EN.
module fetch_ctl
  import fetch_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_data,
  input  logic [7:0] pc_val,
  input  logic       zero_in,
  input  logic       carry_in,
`ifdef FETCH_CTL_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       PCincr,
  output logic [7:0] pc_data,
  output logic [7:0] ir,
  output logic       alu_en,
  output logic       imm_we,
  output logic [7:0] imm,
  output logic       halted
);

  state_t     state, nstate;
  logic       z_q, c_q;
  logic [7:0] imm_q;
  logic       go;
  logic       taken;

`ifdef FETCH_CTL_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  fetch_cond u_cond (
    .cond  (ir[1:0]),
    .z     (z_q),
    .c     (c_q),
    .taken (taken)
  );

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nstate;
  end

  // Next state: fetch dispatches on the incoming byte's class
  always_comb begin
    nstate = state;
    case (state)
      FETCH: begin
        if (go) begin
          case (op_class(rom_data))
            OPC_ALU:  nstate = EXEC;
            OPC_LDI:  nstate = OPERAND;
            OPC_JMP:  nstate = OPERAND;
            default:  nstate = (rom_data == OP_HALT) ? HALT : FETCH;
          endcase
        end
      end
      EXEC:    nstate = FETCH;
      OPERAND: nstate = FETCH;
      HALT:    nstate = HALT;
      default: nstate = FETCH;
    endcase
  end

  // Datapath registers: ir on fetch, flags on exec, immediate on LDI operand
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir    <= 8'h00;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      imm_q <= 8'h00;
    end else begin
      if (state == FETCH && go) ir <= rom_data;
      if (state == EXEC) begin
        z_q <= zero_in;
        c_q <= carry_in;
      end
      if (state == OPERAND && op_class(ir) == OPC_LDI) imm_q <= rom_data;
    end
  end

  // Outputs: PC holds by reloading pc_val on every non-advancing cycle
  always_comb begin
    PCincr  = 1'b1;
    pc_data = pc_val;
    alu_en  = 1'b0;
    imm_we  = 1'b0;
    imm     = imm_q;
    halted  = 1'b0;
    case (state)
      FETCH: PCincr = go;
      EXEC: begin
        PCincr = 1'b0;
        alu_en = 1'b1;
      end
      OPERAND: begin
        if (op_class(ir) == OPC_LDI) begin
          imm_we = 1'b1;
          imm    = rom_data;
        end else if (op_class(ir) == OPC_JMP && taken) begin
          PCincr  = 1'b0;
          pc_data = rom_data;
        end
      end
      HALT: begin
        PCincr = 1'b0;
        halted = 1'b1;
      end
      default: PCincr = 1'b1;
    endcase
  end

endmodule
